instr_fetch_ctrl: RTL
=====================

Name: instr_fetch_ctrl

Overview:
- Sequences the word-addressed instruction ROM: owns the fetch PC and drives the ROM address.
- Captures the combinational read data into a small FIFO and presents instructions to decode with a valid/ready handshake.
- Handles stalls, branch/jump redirects with flush, and faults on misaligned redirect targets.
- Sits between the instruction ROM and the decode stage.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and ROM address.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; must be word aligned.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  fetch enable; low stops new fetches, FIFO still drains.
- redirect_i  input  1  branch/jump taken; flush and reload PC.
- redirect_pc_i  input  ADDRESS_WIDTH  redirect target.
- imem_addr_o  output  ADDRESS_WIDTH  ROM byte address (ROM uses bits [11:2]).
- imem_rd_i  input  32  ROM read data, combinational from imem_addr_o.
- instr_o  output  32  instruction at FIFO head.
- pc_o  output  ADDRESS_WIDTH  PC of the instruction at FIFO head.
- valid_o  output  1  FIFO head holds a valid instruction.
- ready_i  input  1  decode accepts the head this cycle.
- fill_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
- fault_o  output  1  sticky misaligned-redirect fault.

Behaviour:
- Reset (asynchronous, immediate) values:
  - fetch PC fpc = RESET_PC; FIFO empty; fill_o = 0; valid_o = 0; fault_o = 0; state = RUN.
  - instr_o and pc_o are 0 while empty.
- imem_addr_o = fpc at all times, combinational from the register.
- Dequeue: when valid_o && ready_i, the head is removed at the clock edge.
- Enqueue: when state == RUN && en_i && !redirect_i && (fill < DEPTH || dequeue).
  - Writes {fpc, imem_rd_i} at the tail.
  - fpc <= fpc + 4, wrapping modulo 2^ADDRESS_WIDTH with no flag.
- Full with simultaneous dequeue: enqueue and dequeue both occur; fill unchanged.
- Empty: valid_o = 0; ready_i is ignored; there is no combinational bypass.
- Latency: an instruction fetched at edge N is presented with valid_o = 1 in cycle N+1.
- Redirect (redirect_i = 1 at an edge) has priority over enqueue and dequeue:
  - FIFO flushed to fill = 0; any concurrent dequeue is discarded, and decode must not consume that cycle.
  - If redirect_pc_i[1:0] == 0: fpc <= redirect_pc_i; state stays or becomes RUN.
  - Otherwise: fault_o <= 1; state <= HALT; fpc unchanged.
  - The first target instruction is valid two cycles after the redirect edge: flush edge, fetch edge, then presented.
- States:
  - RUN: fetches per the enqueue rule.
  - HALT: no fetch, FIFO empty, valid_o = 0; redirects ignored; exits only on rst_i.
  - en_i low is not a separate state, just no enqueue.
- en_i low: the FIFO drains normally and fpc holds.
- Reset mid-operation: contents are discarded immediately. After release, the first fetch is RESET_PC on the first edge with en_i = 1.
- FIFO: circular read/write pointers; fill_o is the registered count.
- All outputs come from registers, except imem_addr_o (registered fpc) and instr_o/pc_o (FIFO head mux).

Test Plan:
- Reset with RESET_PC = 0, en_i = 1, ready_i = 1, ROM words 0x11,0x22,0x33 at byte addresses 0,4,8 -> valid_o rises cycle 1; instr_o/pc_o = 0x11/0, 0x22/4, 0x33/8 on consecutive cycles.
- ready_i = 0 for 5 cycles -> fill_o saturates at 2; fpc stops at 8; head stays 0x11/0. Then ready_i = 1 -> in-order stream with no gap or duplicate.
- Redirect to 0x40 while full, with ready_i = 1 that cycle -> fill_o = 0 next cycle; valid_o = 0 one cycle; then pc_o = 0x40 and instr_o = ROM[0x40]; old entries never reappear.
- Redirect to 0x42 -> fault_o = 1 sticky, valid_o = 0 thereafter, imem_addr_o frozen; a later aligned redirect is ignored; rst_i clears fault_o.
- fpc = 0xFFFF_FFFC fetch -> next pc_o = 0x0000_0000 (wrap); assert rst_i asynchronously mid-stream -> valid_o/fill_o drop to 0 immediately, without waiting for a clock edge.
- en_i = 0 with 2 entries and ready_i = 1 -> both entries drain, then valid_o = 0 and fpc holds; en_i = 1 resumes at the held fpc.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads the word-addressed ROM and
// buffers {pc, instr} pairs in a small FIFO for decode. Redirects flush the FIFO; misaligned targets halt fetch.
module instr_fetch_ctrl #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = 32'h0000_0000,
  parameter int unsigned                DEPTH         = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          redirect_i,
  input  logic [ADDRESS_WIDTH-1:0]      redirect_pc_i,
  output logic [ADDRESS_WIDTH-1:0]      imem_addr_o,
  input  logic [31:0]                   imem_rd_i,
  output logic [31:0]                   instr_o,
  output logic [ADDRESS_WIDTH-1:0]      pc_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(DEPTH):0]        fill_o,
  output logic                          fault_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fpc_q, fpc_d;
  logic                     fault_q, fault_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic                     enq, deq;

  logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
  logic [31:0]              instr_mem [DEPTH];

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    fault_d  = fault_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    enq      = 1'b0;
    deq      = (fill_q != '0) && ready_i;

    if (state_q == RUN) begin
      if (redirect_i) begin
        // Flush wins over any handshake this cycle; decode must not consume.
        deq      = 1'b0;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        fill_d   = '0;
        if (redirect_pc_i[1:0] == 2'b00) begin
          fpc_d = redirect_pc_i;
        end else begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end else begin
        enq = en_i && ((fill_q < FILL_W'(DEPTH)) || deq);
        if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (enq) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          fpc_d    = fpc_q + ADDRESS_WIDTH'(4);
        end
        case ({enq, deq})
          2'b10:   fill_d = fill_q + FILL_W'(1);
          2'b01:   fill_d = fill_q - FILL_W'(1);
          default: fill_d = fill_q;
        endcase
      end
    end else begin
      // HALT keeps the FIFO empty, so nothing can be dequeued either.
      deq = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      fpc_q    <= RESET_PC;
      fault_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      fault_q  <= fault_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: FIFO storage has no reset; fill_q alone decides validity and the head mux
  // forces zeros when empty, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem[wr_ptr_q]    <= fpc_q;
      instr_mem[wr_ptr_q] <= imem_rd_i;
    end
  end

  assign imem_addr_o = fpc_q;
  assign valid_o     = (fill_q != '0);
  assign instr_o     = valid_o ? instr_mem[rd_ptr_q] : 32'h0;
  assign pc_o        = valid_o ? pc_mem[rd_ptr_q] : '0;
  assign fill_o      = fill_q;
  assign fault_o     = fault_q;

endmodule
